// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/hazard_cmp.sv
// Single source/destination register match; the zero register never produces a hit.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter logic [4:0] XZR = XZR_IDX
) (
  input  logic [4:0] src,
  input  logic [4:0] dst,
  input  logic       wr,
  input  logic       use_src,
  output logic       hit
);

  assign hit = use_src && wr && (dst == src) && (dst != XZR);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline.
// Define HAZARD_FWD_EN to enable EX-stage forwarding (only load-use hazards then stall).
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int         CNT_W = 32,
  parameter logic [4:0] XZR   = XZR_IDX
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [4:0]       ex_rn,
  input  logic [4:0]       ex_rm,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             mem_br_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e     state, state_nxt;
  logic [1:0] rem, rem_nxt;
  logic [1:0] req;
  logic       hit_rn_ex, hit_rm_ex, hit_ex;

  hazard_cmp #(.XZR(XZR)) u_rn_ex (.src(id_rn), .dst(ex_rd), .wr(ex_regwrite),
                                   .use_src(id_use_rn), .hit(hit_rn_ex));
  hazard_cmp #(.XZR(XZR)) u_rm_ex (.src(id_rm), .dst(ex_rd), .wr(ex_regwrite),
                                   .use_src(id_use_rm), .hit(hit_rm_ex));
  assign hit_ex = hit_rn_ex || hit_rm_ex;

`ifdef HAZARD_FWD_EN
  logic fa_mem, fa_wb, fb_mem, fb_wb;

  hazard_cmp #(.XZR(XZR)) u_fa_mem (.src(ex_rn), .dst(mem_rd), .wr(mem_regwrite),
                                    .use_src(1'b1), .hit(fa_mem));
  hazard_cmp #(.XZR(XZR)) u_fa_wb  (.src(ex_rn), .dst(wb_rd), .wr(wb_regwrite),
                                    .use_src(1'b1), .hit(fa_wb));
  hazard_cmp #(.XZR(XZR)) u_fb_mem (.src(ex_rm), .dst(mem_rd), .wr(mem_regwrite),
                                    .use_src(1'b1), .hit(fb_mem));
  hazard_cmp #(.XZR(XZR)) u_fb_wb  (.src(ex_rm), .dst(wb_rd), .wr(wb_regwrite),
                                    .use_src(1'b1), .hit(fb_wb));

  // With forwarding, only a load feeding the next instruction needs a single bubble.
  assign req = (ex_memread && hit_ex) ? 2'd1 : 2'd0;

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (!Reset) begin
      if (fa_mem)     fwd_a = FWD_MEM;
      else if (fa_wb) fwd_a = FWD_WB;
      if (fb_mem)     fwd_b = FWD_MEM;
      else if (fb_wb) fwd_b = FWD_WB;
    end
  end
`else
  logic hit_rn_mem, hit_rm_mem, hit_rn_wb, hit_rm_wb;
  logic unused_fwd_inputs;

  hazard_cmp #(.XZR(XZR)) u_rn_mem (.src(id_rn), .dst(mem_rd), .wr(mem_regwrite),
                                    .use_src(id_use_rn), .hit(hit_rn_mem));
  hazard_cmp #(.XZR(XZR)) u_rm_mem (.src(id_rm), .dst(mem_rd), .wr(mem_regwrite),
                                    .use_src(id_use_rm), .hit(hit_rm_mem));
  hazard_cmp #(.XZR(XZR)) u_rn_wb  (.src(id_rn), .dst(wb_rd), .wr(wb_regwrite),
                                    .use_src(id_use_rn), .hit(hit_rn_wb));
  hazard_cmp #(.XZR(XZR)) u_rm_wb  (.src(id_rm), .dst(wb_rd), .wr(wb_regwrite),
                                    .use_src(id_use_rm), .hit(hit_rm_wb));

  // No regfile bypass: the producer must reach the end of WB, so nearer stages cost more.
  assign req = hit_ex                     ? 2'd3 :
               (hit_rn_mem || hit_rm_mem) ? 2'd2 :
               (hit_rn_wb  || hit_rm_wb)  ? 2'd1 : 2'd0;

  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
  assign unused_fwd_inputs = ^{ex_rn, ex_rm, ex_memread};
`endif

  // NOTE: every output gets a default first, so no path through this block infers a latch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_nxt   = state;
    rem_nxt     = rem;
    if (Reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      state_nxt   = RUN;
      rem_nxt     = 2'd0;
    end else if (mem_br_taken) begin
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      state_nxt   = RUN;
      rem_nxt     = 2'd0;
    end else if (state == STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      rem_nxt     = rem - 2'd1;
      if (rem <= 2'd1) state_nxt = RUN;
    end else if (req != 2'd0) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (req > 2'd1) begin
        rem_nxt   = req - 2'd1;
        state_nxt = STALL;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= RUN;
      rem       <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (!pc_write && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (mem_br_taken && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
